// File: rtl/multdiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit and its decoder.
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic [4:0] ALUOP_MUL = 5'b00110;
    localparam logic [4:0] ALUOP_DIV = 5'b00111;

endpackage

// File: rtl/multdiv_iter_if.sv
// Start/result handshake between the DX/MW pipeline stages and the multiply/divide unit.
interface multdiv_iter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic             ctrl_cancel;
    logic [TAG_W-1:0] tag_in;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, ctrl_cancel, tag_in,
        input  data_result, data_exception, data_resultRDY, busy, tag_out
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, ctrl_cancel, tag_in,
        output data_result, data_exception, data_resultRDY, busy, tag_out
    );
endinterface

// File: rtl/md_iter_counter.sv
// Iteration index for multdiv_iter; last flags the final step of an op.
module md_iter_counter #(
    parameter int WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     en,
    output logic [$clog2(WIDTH)-1:0] count,
    output logic                     last
);
    localparam int CNT_W = $clog2(WIDTH);

    // Iteration count register; clear has priority over increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= {CNT_W{1'b0}};
        end else if (clear) begin
            count <= {CNT_W{1'b0}};
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit with a
// fixed WIDTH+1 cycle latency and a destination tag carried to the result.
module multdiv_iter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input logic           clock,
    input logic           reset,
    multdiv_iter_if.slave md
);
    import multdiv_pkg::*;

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam int                PW       = 2 * WIDTH + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]  ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]  MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic             busy_q, rdy_q, exc_q;
    logic [WIDTH-1:0] result_q;
    logic [TAG_W-1:0] tag_q, tag_out_q;
    logic             div_op_q, neg_q, div_zero_q, div_ovf_q;
    logic [WIDTH-1:0] mcand_q, dvsr_q, rem_q, quot_q;
    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0] rem_d, quot_d, div_sub_s, abs_a_s, abs_b_s, fin_res_s;
    logic [WIDTH:0]   acc_ext_s, mcand_ext_s, booth_sum_s, div_shift_s;
    logic             fin_exc_s;
    logic             start_mul_s, start_div_s, start_s, running_s;
    logic             last_s, cnt_clear_s, cnt_en_s;
    logic [CNT_W-1:0] cnt_s;

    // Both start strobes high at once is not a valid request and is ignored.
    assign start_mul_s = md.ctrl_MULT & ~md.ctrl_DIV;
    assign start_div_s = md.ctrl_DIV & ~md.ctrl_MULT;
    assign start_s     = start_mul_s | start_div_s;
    assign running_s   = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign cnt_clear_s = start_s | md.ctrl_cancel | (state_q == ST_DONE);
    assign cnt_en_s    = running_s & (cnt_s != LAST_CNT);
    assign abs_a_s     = md.data_operandA[WIDTH-1] ? (ZERO - md.data_operandA) : md.data_operandA;
    assign abs_b_s     = md.data_operandB[WIDTH-1] ? (ZERO - md.data_operandB) : md.data_operandB;

    md_iter_counter #(.WIDTH(WIDTH)) u_cnt (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clear_s),
        .en    (cnt_en_s),
        .count (cnt_s),
        .last  (last_s)
    );

    // Next-state logic: a new start overrides cancel and any op in flight.
    always_comb begin
        state_d = state_q;
        if (start_mul_s) begin
            state_d = ST_MUL;
        end else if (start_div_s) begin
            state_d = ST_DIV;
        end else if (md.ctrl_cancel) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_MUL, ST_DIV: begin
                    if (last_s) state_d = ST_DONE;
                    else        state_d = state_q;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // One Booth step: acc +/- multiplicand with one guard bit, then arithmetic shift.
    always_comb begin
        acc_ext_s   = {prod_q[PW-1], prod_q[PW-1:WIDTH+1]};
        mcand_ext_s = {mcand_q[WIDTH-1], mcand_q};
        case (prod_q[1:0])
            2'b01:   booth_sum_s = acc_ext_s + mcand_ext_s;
            2'b10:   booth_sum_s = acc_ext_s - mcand_ext_s;
            default: booth_sum_s = acc_ext_s;
        endcase
        prod_d = {booth_sum_s, prod_q[WIDTH:1]};
    end

    // One restoring-division step on magnitudes; the partial remainder always fits WIDTH bits.
    always_comb begin
        div_shift_s = {rem_q, quot_q[WIDTH-1]};
        div_sub_s   = div_shift_s[WIDTH-1:0] - dvsr_q;
        rem_d       = div_shift_s[WIDTH-1:0];
        quot_d      = {quot_q[WIDTH-2:0], 1'b0};
        if (div_shift_s >= {1'b0, dvsr_q}) begin
            rem_d  = div_sub_s;
            quot_d = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d  = div_shift_s[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b0};
        end
    end

    // Final result and exception selection, including the quotient sign fix.
    always_comb begin
        fin_res_s = prod_q[WIDTH:1];
        fin_exc_s = (prod_q[PW-1:WIDTH+1] != {WIDTH{prod_q[WIDTH]}});
        if (div_op_q) begin
            if (div_zero_q) begin
                fin_res_s = ZERO;
                fin_exc_s = 1'b1;
            end else begin
                fin_res_s = neg_q ? (ZERO - quot_q) : quot_q;
                fin_exc_s = div_ovf_q;
            end
        end else begin
            fin_res_s = prod_q[WIDTH:1];
            fin_exc_s = (prod_q[PW-1:WIDTH+1] != {WIDTH{prod_q[WIDTH]}});
        end
    end

    // State and busy registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // Operand capture on start, then one iteration per cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_op_q   <= 1'b0;
            tag_q      <= {TAG_W{1'b0}};
            mcand_q    <= ZERO;
            prod_q     <= {PW{1'b0}};
            dvsr_q     <= ZERO;
            quot_q     <= ZERO;
            rem_q      <= ZERO;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            div_ovf_q  <= 1'b0;
        end else if (start_s) begin
            div_op_q   <= start_div_s;
            tag_q      <= md.tag_in;
            mcand_q    <= md.data_operandA;
            prod_q     <= {ZERO, md.data_operandB, 1'b0};
            dvsr_q     <= abs_b_s;
            quot_q     <= abs_a_s;
            rem_q      <= ZERO;
            neg_q      <= md.data_operandA[WIDTH-1] ^ md.data_operandB[WIDTH-1];
            div_zero_q <= (md.data_operandB == ZERO);
            div_ovf_q  <= (md.data_operandA == MIN_VAL) && (md.data_operandB == ALL_ONES);
        end else if (state_q == ST_MUL) begin
            prod_q <= prod_d;
        end else if (state_q == ST_DIV) begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
        end
    end

    // Result registers update only on completion and otherwise hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdy_q     <= 1'b0;
            result_q  <= ZERO;
            exc_q     <= 1'b0;
            tag_out_q <= {TAG_W{1'b0}};
        end else begin
            rdy_q <= 1'b0;
            if ((state_q == ST_DONE) && !start_s && !md.ctrl_cancel) begin
                rdy_q     <= 1'b1;
                result_q  <= fin_res_s;
                exc_q     <= fin_exc_s;
                tag_out_q <= tag_q;
            end
        end
    end

    assign md.data_result    = result_q;
    assign md.data_exception = exc_q;
    assign md.data_resultRDY = rdy_q;
    assign md.busy           = busy_q;
    assign md.tag_out        = tag_out_q;

endmodule

// File: tb/tb_multdiv_iter.sv
// Directed self-checking bench for multdiv_iter at WIDTH=32.
module tb_multdiv_iter;
    localparam int W  = 32;
    localparam int TW = 5;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    multdiv_iter_if #(.WIDTH(W), .TAG_W(TW)) md ();

    multdiv_iter #(.WIDTH(W), .TAG_W(TW)) dut (
        .clock (clock),
        .reset (reset),
        .md    (md)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue a start at the next rising edge (edge k); returns at the falling edge after k.
    task automatic start_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] tag);
        md.data_operandA = a;
        md.data_operandB = b;
        md.tag_in        = tag;
        md.ctrl_MULT     = ~is_div;
        md.ctrl_DIV      = is_div;
        @(posedge clock);
        @(negedge clock);
        md.ctrl_MULT     = 1'b0;
        md.ctrl_DIV      = 1'b0;
        md.data_operandA = 32'hDEAD_BEEF;
        md.data_operandB = 32'h0000_0003;
        md.tag_in        = 5'd31;
    endtask

    task automatic wait_rdy(input int max_cyc, output int lat);
        lat = -1;
        for (int n = 1; n <= max_cyc; n++) begin
            @(posedge clock);
            @(negedge clock);
            if (md.data_resultRDY === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic idle(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (md.data_resultRDY === 1'b1) pulses++;
        end
    endtask

    task automatic run_op(input string name, input logic is_div, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] exp_res, input logic exp_exc);
        int lat;
        start_op(is_div, a, b, tag);
        check({name, ".busy_start"}, 32'(md.busy), 32'd1);
        wait_rdy(40, lat);
        check({name, ".latency"}, 32'(lat), 32'd33);
        check({name, ".result"}, md.data_result, exp_res);
        check({name, ".exc"}, 32'(md.data_exception), 32'(exp_exc));
        check({name, ".tag"}, 32'(md.tag_out), 32'(tag));
        check({name, ".busy_rdy"}, 32'(md.busy), 32'd0);
        @(posedge clock);
        @(negedge clock);
        check({name, ".rdy_pulse"}, 32'(md.data_resultRDY), 32'd0);
        check({name, ".hold"}, md.data_result, exp_res);
    endtask

    initial begin
        int p;
        int lat;
        reset            = 1'b1;
        md.data_operandA = 32'd0;
        md.data_operandB = 32'd0;
        md.ctrl_MULT     = 1'b0;
        md.ctrl_DIV      = 1'b0;
        md.ctrl_cancel   = 1'b0;
        md.tag_in        = 5'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset.busy", 32'(md.busy), 32'd0);
        check("reset.rdy", 32'(md.data_resultRDY), 32'd0);
        check("reset.result", md.data_result, 32'd0);
        check("reset.exc", 32'(md.data_exception), 32'd0);
        check("reset.tag", 32'(md.tag_out), 32'd0);

        run_op("mul_7x-3",     1'b0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0);
        run_op("mul_ovf",      1'b0, 32'h0001_0000,  32'h0001_0000, 5'd6,  32'h0000_0000, 1'b1);
        run_op("mul_minx1",    1'b0, 32'h8000_0000,  32'd1,         5'd7,  32'h8000_0000, 1'b0);
        run_op("mul_minx-1",   1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 5'd8,  32'h8000_0000, 1'b1);
        run_op("div_-7/2",     1'b1, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 1'b0);
        run_op("div_5/0",      1'b1, 32'd5,          32'd0,         5'd10, 32'h0000_0000, 1'b1);
        run_op("div_min/-1",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b1);
        run_op("div_100/-7",   1'b1, 32'd100,        32'hFFFF_FFF9, 5'd12, 32'hFFFF_FFF2, 1'b0);

        // Restart: MUL at k, DIV at k+10 replaces it.
        start_op(1'b0, 32'd3, 32'd4, 5'd1);
        idle(9, p);
        check("restart.no_rdy_first", 32'(p), 32'd0);
        start_op(1'b1, 32'd100, 32'd7, 5'd2);
        wait_rdy(40, lat);
        check("restart.latency", 32'(lat), 32'd33);
        check("restart.result", md.data_result, 32'd14);
        check("restart.tag", 32'(md.tag_out), 32'd2);
        idle(5, p);
        check("restart.single_rdy", 32'(p), 32'd0);

        // Cancel at k+5 drops the op; previous result stays.
        start_op(1'b0, 32'd7, 32'hFFFF_FFFD, 5'd3);
        idle(4, p);
        md.ctrl_cancel = 1'b1;
        @(posedge clock);
        @(negedge clock);
        md.ctrl_cancel = 1'b0;
        check("cancel.busy", 32'(md.busy), 32'd0);
        idle(40, p);
        check("cancel.no_rdy", 32'(p), 32'd0);
        check("cancel.result_kept", md.data_result, 32'd14);
        check("cancel.tag_kept", 32'(md.tag_out), 32'd2);

        // Both start strobes high: ignored.
        md.data_operandA = 32'd9;
        md.data_operandB = 32'd9;
        md.ctrl_MULT     = 1'b1;
        md.ctrl_DIV      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        md.ctrl_MULT = 1'b0;
        md.ctrl_DIV  = 1'b0;
        check("both.busy", 32'(md.busy), 32'd0);
        idle(40, p);
        check("both.no_rdy", 32'(p), 32'd0);
        check("both.result_kept", md.data_result, 32'd14);

        // Reset in the middle of a DIV clears everything at once.
        start_op(1'b1, 32'd100, 32'd7, 5'd7);
        idle(11, p);
        check("rst_mid.busy_before", 32'(md.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid.busy", 32'(md.busy), 32'd0);
        check("rst_mid.rdy", 32'(md.data_resultRDY), 32'd0);
        check("rst_mid.result", md.data_result, 32'd0);
        check("rst_mid.exc", 32'(md.data_exception), 32'd0);
        check("rst_mid.tag", 32'(md.tag_out), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        idle(40, p);
        check("rst_mid.no_rdy", 32'(p), 32'd0);
        check("rst_mid.idle", 32'(md.busy), 32'd0);

        run_op("mul_-1x-1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
